// File: rtl/uart_boot_pkg.sv
// uart_boot_pkg: shared types and defaults for the UART boot loader.
//   boot_state_t  - loader FSM states
//   DEF_ACK_BYTE  - default byte returned after a successful load
//   DEF_ERR_BYTE  - default byte returned when the word count is rejected
//   max_words()   - capacity of an instruction memory with the given word-address width
package uart_boot_pkg;

  typedef enum logic [2:0] {S_LEN, S_DATA, S_WRITE, S_ACK, S_DONE, S_ERR} boot_state_t;

  localparam logic [7:0] DEF_ACK_BYTE = 8'hAA;
  localparam logic [7:0] DEF_ERR_BYTE = 8'hEE;

  function automatic logic [31:0] max_words(input int unsigned addr_width);
    return 32'(1) << addr_width;
  endfunction

endpackage

// File: rtl/uart_boot_loader_word_assembler.sv
// word_assembler: builds little-endian 32-bit words from a byte stream.
//   clk, rst      - system clock, asynchronous active-high reset
//   i_pop         - a byte is consumed this cycle
//   i_byte        - the byte being consumed
//   o_word        - assembled word, valid together with o_word_valid
//   o_word_valid  - pulses on the 4th pop of each word
module word_assembler
  import uart_boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_pop,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [31:0] r_sr;
  logic [1:0]  r_bcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr   <= '0;
      r_bcnt <= '0;
    end else if (i_pop) begin
      r_sr   <= {i_byte, r_sr[31:8]};
      r_bcnt <= r_bcnt + 2'd1;
    end
  end

  // The completing byte is taken straight from the input so the word is
  // usable in the same cycle as its last pop.
  assign o_word       = {i_byte, r_sr[31:8]};
  assign o_word_valid = i_pop && (r_bcnt == 2'd3);

endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: consumes a host stream (32-bit word count N, then N words,
// all little-endian) from the RX FIFO, writes the words to instruction memory,
// answers with one ack/error byte on the TX FIFO and then flags completion.
//   clk, rst    - system clock, asynchronous active-high reset
//   rx_data     - RX FIFO head byte (first-word fall-through)
//   rx_empty    - RX FIFO empty
//   rx_rd_en    - pop RX FIFO head this cycle
//   tx_data     - byte pushed to the TX FIFO
//   tx_full     - TX FIFO full
//   tx_wr_en    - push tx_data this cycle
//   imem_addr   - instruction memory word address
//   imem_wdata  - instruction memory write data
//   imem_we     - single-cycle instruction memory write strobe
//   done        - load complete, sticky until rst
//   err         - length rejected, sticky until rst
module uart_boot_loader
  import uart_boot_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned BASE_ADDR  = 0,
  parameter logic [7:0]  ACK_BYTE   = DEF_ACK_BYTE,
  parameter logic [7:0]  ERR_BYTE   = DEF_ERR_BYTE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_empty,
  output logic                  rx_rd_en,
  output logic [7:0]            tx_data,
  input  logic                  tx_full,
  output logic                  tx_wr_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  imem_we,
  output logic                  done,
  output logic                  err
);

  localparam logic [31:0] MAX_WORDS = max_words(ADDR_WIDTH);

  boot_state_t           r_state;
  boot_state_t           w_state_nxt;
  logic [31:0]           r_count;
  // One bit wider than the address so a full-memory load ends without wrapping.
  logic [ADDR_WIDTH:0]   r_idx;
  logic [ADDR_WIDTH:0]   w_idx_inc;
  logic                  r_err_sent;
  logic                  w_pop;
  logic [31:0]           w_word;
  logic                  w_word_valid;
  logic [31:0]           w_addr_full;

  assign w_pop       = ((r_state == S_LEN) || (r_state == S_DATA)) && !rx_empty;
  assign rx_rd_en    = w_pop;
  assign w_idx_inc   = r_idx + (ADDR_WIDTH+1)'(1);
  assign w_addr_full = BASE_ADDR + 32'(r_idx);

  word_assembler u_word_assembler (
    .clk          (clk),
    .rst          (rst),
    .i_pop        (w_pop),
    .i_byte       (rx_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    imem_we     = 1'b0;
    tx_wr_en    = 1'b0;
    tx_data     = '0;
    done        = 1'b0;
    err         = 1'b0;
    case (r_state)
      S_LEN: begin
        if (w_word_valid) begin
          if (w_word == '0)          w_state_nxt = S_ACK;
          else if (w_word > MAX_WORDS) w_state_nxt = S_ERR;
          else                       w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_word_valid) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        imem_we = 1'b1;
        if (32'(w_idx_inc) == r_count) w_state_nxt = S_ACK;
        else                           w_state_nxt = S_DATA;
      end
      S_ACK: begin
        if (!tx_full) begin
          tx_wr_en    = 1'b1;
          tx_data     = ACK_BYTE;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
      end
      S_ERR: begin
        // Terminal state; r_err_sent limits the error byte to a single push.
        err = 1'b1;
        if (!tx_full && !r_err_sent) begin
          tx_wr_en = 1'b1;
          tx_data  = ERR_BYTE;
        end
      end
      default: w_state_nxt = S_LEN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_LEN;
      r_count    <= '0;
      r_idx      <= '0;
      r_err_sent <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_LEN) && w_word_valid) r_count <= w_word;
      if ((r_state == S_DATA) && w_word_valid) begin
        imem_wdata <= w_word;
        imem_addr  <= w_addr_full[ADDR_WIDTH-1:0];
      end
      if (r_state == S_WRITE) r_idx <= w_idx_inc;
      if ((r_state == S_ERR) && tx_wr_en) r_err_sent <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
module tb_uart_boot_loader;

  localparam int unsigned AW   = 15;
  localparam int unsigned MAXW = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          tx_full;
  logic [7:0]    rx_data_a,  rx_data_b;
  logic          rx_empty_a, rx_empty_b;
  logic          rx_rd_en_a, rx_rd_en_b;
  logic [7:0]    tx_data_a,  tx_data_b;
  logic          tx_wr_en_a, tx_wr_en_b;
  logic [AW-1:0] imem_addr_a, imem_addr_b;
  logic [31:0]   imem_wdata_a, imem_wdata_b;
  logic          imem_we_a, imem_we_b;
  logic          done_a, done_b, err_a, err_b;

  uart_boot_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0), .ACK_BYTE(8'hAA), .ERR_BYTE(8'hEE)) dut_a (
    .clk(clk), .rst(rst), .rx_data(rx_data_a), .rx_empty(rx_empty_a), .rx_rd_en(rx_rd_en_a),
    .tx_data(tx_data_a), .tx_full(tx_full), .tx_wr_en(tx_wr_en_a), .imem_addr(imem_addr_a),
    .imem_wdata(imem_wdata_a), .imem_we(imem_we_a), .done(done_a), .err(err_a));

  uart_boot_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(16), .ACK_BYTE(8'hAA), .ERR_BYTE(8'hEE)) dut_b (
    .clk(clk), .rst(rst), .rx_data(rx_data_b), .rx_empty(rx_empty_b), .rx_rd_en(rx_rd_en_b),
    .tx_data(tx_data_b), .tx_full(tx_full), .tx_wr_en(tx_wr_en_b), .imem_addr(imem_addr_b),
    .imem_wdata(imem_wdata_b), .imem_we(imem_we_b), .done(done_b), .err(err_b));

  int tests = 0;
  int fails = 0;

  logic [7:0]  rxq_a[$], rxq_b[$];
  logic [7:0]  txq_a[$], txq_b[$];
  int          wa_addr[$], wb_addr[$];
  logic [31:0] wa_data[$], wb_data[$];
  int          pops_a, pops_b, cyc, last_pop_b, done_cyc_b, tx_cyc_a, last_we_a;
  bit          gap_en;
  bit          tx_full_req;

  // Word k of a little-endian byte stream (word 0 is the count).
  function automatic logic [31:0] le_word(input logic [7:0] s[$], input int k);
    return {s[4*k+3], s[4*k+2], s[4*k+1], s[4*k]};
  endfunction

  // One clock: drive FIFO heads on the falling edge, sample outputs 1ns later,
  // and account for whatever the coming rising edge will consume or produce.
  task automatic cycle();
    @(negedge clk);
    rx_empty_a = (rxq_a.size() == 0) || (gap_en && ($urandom_range(0, 1) == 1));
    rx_data_a  = (rxq_a.size() > 0) ? rxq_a[0] : 8'h00;
    rx_empty_b = (rxq_b.size() == 0);
    rx_data_b  = (rxq_b.size() > 0) ? rxq_b[0] : 8'h00;
    tx_full    = tx_full_req;
    #1;
    cyc++;
    if (rx_rd_en_a) begin
      tests++;
      if (rx_empty_a) begin
        fails++;
        $display("FAIL rd_en_while_empty: rx_rd_en=1 with rx_empty=1 at cycle %0d", cyc);
      end else begin
        void'(rxq_a.pop_front());
        pops_a++;
      end
    end
    if (rx_rd_en_b && !rx_empty_b) begin
      void'(rxq_b.pop_front());
      pops_b++;
      last_pop_b = cyc;
    end
    if (tx_wr_en_a) begin
      tests++;
      if (tx_full) begin
        fails++;
        $display("FAIL tx_while_full: tx_wr_en=1 with tx_full=1 at cycle %0d", cyc);
      end
      txq_a.push_back(tx_data_a);
      tx_cyc_a = cyc;
    end
    if (tx_wr_en_b) txq_b.push_back(tx_data_b);
    if (imem_we_a) begin
      wa_addr.push_back(int'(imem_addr_a));
      wa_data.push_back(imem_wdata_a);
      last_we_a = cyc;
    end
    if (imem_we_b) begin
      wb_addr.push_back(int'(imem_addr_b));
      wb_data.push_back(imem_wdata_b);
    end
    if (done_b && done_cyc_b < 0) done_cyc_b = cyc;
  endtask

  task automatic clear_obs();
    rxq_a.delete(); rxq_b.delete(); txq_a.delete(); txq_b.delete();
    wa_addr.delete(); wa_data.delete(); wb_addr.delete(); wb_data.delete();
    pops_a = 0; pops_b = 0; cyc = 0; last_pop_b = -1; done_cyc_b = -1;
    tx_cyc_a = -1; last_we_a = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_obs();
    gap_en = 1'b0; tx_full_req = 1'b0; tx_full = 1'b0;
    rx_empty_a = 1'b1; rx_empty_b = 1'b1; rx_data_a = '0; rx_data_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_a(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      cycle();
      if (done_a || err_a) break;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_obs();
    rx_empty_a = 1'b1; rx_empty_b = 1'b1; tx_full = 1'b0; tx_full_req = 1'b0;
    #1;
    tests++;
    if ({rx_rd_en_a, tx_wr_en_a, tx_data_a, imem_addr_a, imem_wdata_a, imem_we_a, done_a, err_a,
         rx_rd_en_b, tx_wr_en_b, tx_data_b, imem_addr_b, imem_wdata_b, imem_we_b, done_b, err_b} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: some output nonzero in reset (a: we=%b done=%b err=%b tx=%b)",
               imem_we_a, done_a, err_a, tx_wr_en_a);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cycle();
    tests++;
    if ({tx_wr_en_a, imem_we_a, done_a, err_a, rx_rd_en_a} !== 5'b0) begin
      fails++;
      $display("FAIL reset_idle: got %b expected 00000", {tx_wr_en_a, imem_we_a, done_a, err_a, rx_rd_en_a});
    end
  endtask

  task automatic test_basic_n2();
    logic [7:0] s[$];
    s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_reset();
    rxq_a = s;
    run_a(100);
    repeat (5) cycle();
    tests++;
    if (wa_addr.size() != 2) begin
      fails++; $display("FAIL n2_write_count: got %0d expected 2", wa_addr.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (wa_addr[i] != i || wa_data[i] !== le_word(s, i + 1)) begin
          fails++;
          $display("FAIL n2_write%0d: got addr %0d data %h expected addr %0d data %h",
                   i, wa_addr[i], wa_data[i], i, le_word(s, i + 1));
        end
      end
    end
    tests++;
    if (txq_a.size() != 1 || txq_a[0] !== 8'hAA) begin
      fails++; $display("FAIL n2_ack: got %0d bytes, first %h expected 1 byte AA",
                        txq_a.size(), (txq_a.size() > 0) ? txq_a[0] : 8'h00);
    end
    tests++;
    if (tx_cyc_a != last_we_a + 1) begin
      fails++; $display("FAIL n2_ack_latency: ack at cycle %0d expected %0d", tx_cyc_a, last_we_a + 1);
    end
    tests++;
    if ({done_a, err_a} !== 2'b10 || pops_a != 12) begin
      fails++; $display("FAIL n2_done: got done=%b err=%b pops=%0d expected done=1 err=0 pops=12",
                        done_a, err_a, pops_a);
    end
  endtask

  task automatic test_n0();
    do_reset();
    rxq_a = '{8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) rxq_a.push_back(8'($urandom));
    run_a(50);
    repeat (10) cycle();
    tests++;
    if (wa_addr.size() != 0 || txq_a.size() != 1 || txq_a[0] !== 8'hAA) begin
      fails++; $display("FAIL n0_result: got %0d writes %0d tx bytes expected 0 writes and one AA",
                        wa_addr.size(), txq_a.size());
    end
    tests++;
    if (done_a !== 1'b1 || pops_a != 4 || rxq_a.size() != 4) begin
      fails++; $display("FAIL n0_no_extra_pops: got done=%b pops=%0d left=%0d expected done=1 pops=4 left=4",
                        done_a, pops_a, rxq_a.size());
    end
  endtask

  task automatic test_err();
    logic [31:0] n;
    n = MAXW + 1;
    do_reset();
    for (int i = 0; i < 4; i++) rxq_a.push_back(n[8*i +: 8]);
    for (int i = 0; i < 8; i++) rxq_a.push_back(8'($urandom));
    run_a(50);
    repeat (20) cycle();
    tests++;
    if ({err_a, done_a} !== 2'b10) begin
      fails++; $display("FAIL err_flags: got err=%b done=%b expected err=1 done=0", err_a, done_a);
    end
    tests++;
    if (txq_a.size() != 1 || txq_a[0] !== 8'hEE) begin
      fails++; $display("FAIL err_byte: got %0d bytes first %h expected one EE",
                        txq_a.size(), (txq_a.size() > 0) ? txq_a[0] : 8'h00);
    end
    tests++;
    if (wa_addr.size() != 0 || pops_a != 4) begin
      fails++; $display("FAIL err_quiet: got %0d writes %0d pops expected 0 writes 4 pops",
                        wa_addr.size(), pops_a);
    end
  endtask

  task automatic test_gaps_txfull();
    logic [7:0] s[$];
    int n, after, drop_cyc;
    n = $urandom_range(2, 6);
    for (int i = 0; i < 4; i++) s.push_back(8'(n >> (8*i)));
    for (int i = 0; i < 4*n; i++) s.push_back(8'($urandom));
    do_reset();
    rxq_a = s;
    gap_en = 1'b1;
    tx_full_req = 1'b1;
    after = -1; drop_cyc = -1;
    for (int i = 0; i < 2000; i++) begin
      cycle();
      if (done_a) break;
      if (after >= 0) after++;
      else if (wa_addr.size() == n) after = 0;
      if (after == 20 && tx_full_req) begin
        tx_full_req = 1'b0;
        drop_cyc = cyc;
      end
    end
    tests++;
    if (wa_addr.size() != n) begin
      fails++; $display("FAIL gap_write_count: got %0d expected %0d", wa_addr.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        tests++;
        if (wa_addr[i] != i || wa_data[i] !== le_word(s, i + 1)) begin
          fails++; $display("FAIL gap_write%0d: got addr %0d data %h expected addr %0d data %h",
                            i, wa_addr[i], wa_data[i], i, le_word(s, i + 1));
        end
      end
    end
    tests++;
    if (txq_a.size() != 1 || drop_cyc < 0 || tx_cyc_a != drop_cyc + 1 || done_a !== 1'b1) begin
      fails++; $display("FAIL gap_ack_after_full: ack at cycle %0d (%0d bytes) expected at %0d, done=%b",
                        tx_cyc_a, txq_a.size(), drop_cyc + 1, done_a);
    end
  endtask

  task automatic test_rst_midload();
    logic [7:0] s[$];
    s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_reset();
    rxq_a = s;
    for (int i = 0; i < 100 && pops_a < 6; i++) cycle();
    @(posedge clk);
    #2;
    rst = 1'b1;
    rxq_a.delete();
    rx_empty_a = 1'b1;
    #1;
    tests++;
    if ({rx_rd_en_a, tx_wr_en_a, tx_data_a, imem_addr_a, imem_wdata_a, imem_we_a, done_a, err_a} !== '0) begin
      fails++; $display("FAIL midload_reset_outputs: some output nonzero (we=%b done=%b err=%b)",
                        imem_we_a, done_a, err_a);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_obs();
    rxq_a = s;
    run_a(100);
    repeat (3) cycle();
    tests++;
    if (wa_addr.size() != 2 || wa_addr[0] != 0 || wa_data[0] !== le_word(s, 1)
        || wa_addr[1] != 1 || wa_data[1] !== le_word(s, 2)) begin
      fails++; $display("FAIL midload_reload: got %0d writes first %h expected 2 writes %h %h",
                        wa_addr.size(), (wa_data.size() > 0) ? wa_data[0] : 32'h0, le_word(s, 1), le_word(s, 2));
    end
    tests++;
    if (done_a !== 1'b1 || txq_a.size() != 1) begin
      fails++; $display("FAIL midload_done: got done=%b tx=%0d expected done=1 tx=1", done_a, txq_a.size());
    end
  endtask

  task automatic test_base16();
    logic [7:0] s[$];
    s = '{8'h03, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 12; i++) s.push_back(8'($urandom));
    do_reset();
    rxq_b = s;
    for (int i = 0; i < 200 && !done_b; i++) cycle();
    repeat (3) cycle();
    tests++;
    if (wb_addr.size() != 3) begin
      fails++; $display("FAIL base16_count: got %0d expected 3", wb_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (wb_addr[i] != 16 + i || wb_data[i] !== le_word(s, i + 1)) begin
          fails++; $display("FAIL base16_write%0d: got addr %0d data %h expected addr %0d data %h",
                            i, wb_addr[i], wb_data[i], 16 + i, le_word(s, i + 1));
        end
      end
    end
    // The last pop is committed at the edge closing its cycle; done appears
    // two cycles after that edge.
    tests++;
    if (done_cyc_b - last_pop_b != 3 || txq_b.size() != 1 || txq_b[0] !== 8'hAA) begin
      fails++; $display("FAIL base16_done_timing: done at +%0d cycles, %0d tx bytes, expected +3 and one AA",
                        done_cyc_b - last_pop_b, txq_b.size());
    end
  endtask

  initial begin
    rst = 1'b0; tx_full = 1'b0; tx_full_req = 1'b0; gap_en = 1'b0;
    rx_empty_a = 1'b1; rx_empty_b = 1'b1; rx_data_a = '0; rx_data_b = '0;
    clear_obs();
    test_reset();
    test_basic_n2();
    test_n0();
    test_err();
    test_gaps_txfull();
    test_rst_midload();
    test_base16();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
